// File: rtl/fpu_add_pipe.sv
// fpu_add_pipe: multi-cycle floating-point add/subtract.
// {sign, exp, man} words, round-to-nearest-even, one-hot status.
module fpu_add_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock100KHz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out
);
  localparam int SW  = MAN_W + 4;
  localparam int LZW = $clog2(SW + 1);
  localparam int EXW = EXP_W + LZW + 2;
  localparam logic [EXW-1:0] EMAX = EXW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    IDLE, ALIGN, OPERATE, NORMALIZE, ROUND, OUTPUT
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]          a_q, b_q, byp_w_q;
  logic [SW-1:0]         big_q, sml_q, nrm_q;
  logic [SW:0]           sum_q;
  logic signed [EXW-1:0] exp_q;
  logic                  sgn_q, sub_q, byp_q, zero_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (in_valid) state_nx = ALIGN;
      ALIGN:     state_nx = OPERATE;
      OPERATE:   state_nx = NORMALIZE;
      NORMALIZE: state_nx = ROUND;
      ROUND:     state_nx = OUTPUT;
      OUTPUT:    if (out_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == OUTPUT;

  logic [EXP_W-1:0] ea, eb, e_big, e_sml, d;
  logic             a_big, za, zb;
  logic [SW-1:0]    s_big, s_sml, s_aln;
  logic [2*SW-1:0]  wide;
  logic [W-1:0]     byp_w;

  always_comb begin
    ea    = a_q[W-2:MAN_W];
    eb    = b_q[W-2:MAN_W];
    za    = ea == '0;
    zb    = eb == '0;
    a_big = a_q[W-2:0] >= b_q[W-2:0];
    e_big = a_big ? ea : eb;
    e_sml = a_big ? eb : ea;
    s_big = {1'b1, a_big ? a_q[MAN_W-1:0] : b_q[MAN_W-1:0], 3'b000};
    s_sml = {1'b1, a_big ? b_q[MAN_W-1:0] : a_q[MAN_W-1:0], 3'b000};
    d     = e_big - e_sml;
    wide  = {s_sml, {SW{1'b0}}} >> d;
    // far-away operand survives only as sticky
    if (int'(d) > MAN_W + 3)
      s_aln = {{(SW-1){1'b0}}, 1'b1};
    else
      s_aln = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
    if (za && zb)
      byp_w = {a_q[W-1] & b_q[W-1], {(W-1){1'b0}}};
    else if (za)
      byp_w = b_q;
    else
      byp_w = a_q;
  end

  logic [SW:0] sum;

  always_comb begin
    if (sub_q)
      sum = {1'b0, big_q} - {1'b0, sml_q};
    else
      sum = {1'b0, big_q} + {1'b0, sml_q};
  end

  logic [LZW-1:0]        lz;
  logic [SW-1:0]         nrm_nx;
  logic signed [EXW-1:0] exp_nx;

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (sum_q[i]) lz = LZW'(SW - 1 - i);
    if (sum_q[SW]) begin
      nrm_nx = {sum_q[SW:2], |sum_q[1:0]};
      exp_nx = exp_q + EXW'(1);
    end else begin
      nrm_nx = sum_q[SW-1:0] << lz;
      exp_nx = exp_q - EXW'(lz);
    end
  end

  logic                  g, r, s, up, cy;
  logic [MAN_W+1:0]      rnd;
  logic signed [EXW-1:0] ef;
  logic [MAN_W-1:0]      frac;
  logic [W-1:0]          res;
  logic [3:0]            st;

  always_comb begin
    {g, r, s} = nrm_q[2:0];
    up   = g & (r | s | nrm_q[3]);
    rnd  = {1'b0, nrm_q[SW-1:3]} + (MAN_W+2)'(up);
    cy   = rnd[MAN_W+1];
    ef   = exp_q + EXW'(cy);
    frac = cy ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    res  = {sgn_q, ef[EXP_W-1:0], frac};
    st   = (g | r | s) ? 4'b0010 : 4'b0001;
    if (byp_q) begin
      res = byp_w_q;
      st  = 4'b0001;
    end else if (zero_q) begin
      res = '0;
      st  = 4'b0001;
    end else if (!ef[EXW-1] && ef >= EMAX) begin
      res = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      st  = 4'b0100;
    end else if (ef[EXW-1] || ef == '0) begin
      res = '0;
      st  = 4'b1000;
    end
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      byp_w_q    <= '0;
      big_q      <= '0;
      sml_q      <= '0;
      nrm_q      <= '0;
      sum_q      <= '0;
      exp_q      <= '0;
      sgn_q      <= 1'b0;
      sub_q      <= 1'b0;
      byp_q      <= 1'b0;
      zero_q     <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (in_valid) begin
          a_q <= op_A_in;
          b_q <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
        end
        ALIGN: begin
          big_q   <= s_big;
          sml_q   <= s_aln;
          exp_q   <= EXW'(e_big);
          sgn_q   <= a_big ? a_q[W-1] : b_q[W-1];
          sub_q   <= a_q[W-1] ^ b_q[W-1];
          byp_q   <= za | zb;
          byp_w_q <= byp_w;
        end
        OPERATE: sum_q <= sum;
        NORMALIZE: begin
          nrm_q  <= nrm_nx;
          exp_q  <= exp_nx;
          zero_q <= sum_q == '0;
        end
        ROUND: begin
          data_out   <= res;
          status_out <= st;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_add_pipe.sv
// tb_fpu_add_pipe: directed and random checks of fpu_add_pipe
// against an exact-arithmetic reference model.
module tb_fpu_add_pipe;
  localparam int EW = 6;
  localparam int MW = 25;
  localparam int W  = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] a = '0, b = '0, data_out;
  logic [3:0]   status_out;
  int           ncomp = 0;
  int           nfail = 0;

  fpu_add_pipe dut (
    .clock100KHz(clk),
    .reset(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_A_in(a),
    .op_B_in(b),
    .op_sub(op_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .status_out(status_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exact value = sig * 2^(e-1); round that exact sum to MW+1 bits
  task automatic model(input logic [31:0] ta, input logic [31:0] tb_,
                       input logic sub, output logic [31:0] r,
                       output logic [3:0] st);
    logic sa, sb, sign, inexact;
    int ea, eb, p, sh, e;
    logic signed [127:0] va, vb, sm;
    logic [127:0] mag, q, rem, half;
    sa = ta[31];
    sb = tb_[31] ^ sub;
    ea = int'(ta[30:25]);
    eb = int'(tb_[30:25]);
    r = '0;
    st = 4'b0001;
    if (ea == 0 && eb == 0) begin
      r = {sa & sb, 31'b0};
      return;
    end
    if (ea == 0) begin
      r = {sb, tb_[30:0]};
      return;
    end
    if (eb == 0) begin
      r = ta;
      return;
    end
    va = 128'({1'b1, ta[24:0]}) << (ea - 1);
    vb = 128'({1'b1, tb_[24:0]}) << (eb - 1);
    if (sa) va = -va;
    if (sb) vb = -vb;
    sm = va + vb;
    if (sm == 0) return;
    sign = sm < 0;
    mag = sign ? 128'(-sm) : 128'(sm);
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = p - MW + 1;
    sh = p - MW;
    inexact = 1'b0;
    if (sh > 0) begin
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 128'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      inexact = rem != 0;
    end else begin
      q = mag << (-sh);
    end
    if (q[MW+1]) begin
      q = q >> 1;
      e++;
    end
    if (e >= 63) begin
      r = {sign, 6'h3f, 25'b0};
      st = 4'b0100;
    end else if (e <= 0) begin
      r = '0;
      st = 4'b1000;
    end else begin
      r = {sign, 6'(e), q[24:0]};
      st = inexact ? 4'b0010 : 4'b0001;
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input int hold);
    logic [31:0] er;
    logic [3:0]  es;
    model(ta, tb_, ts, er, es);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    a = ta;
    b = tb_;
    op_sub = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op_sub = 1'($urandom);
    repeat (4) @(negedge clk);
    chk("out_valid_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(1));
    chk("data", 64'(data_out), 64'(er));
    chk("status", 64'(status_out), 64'(es));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'(i % 2 == 0);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      chk("hold_data", 64'(data_out), 64'(er));
      chk("hold_status", 64'(status_out), 64'(es));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consumed_valid", 64'(out_valid), 64'(0));
    chk("consumed_idle", 64'(in_ready), 64'(1));
  endtask

  function automatic logic [31:0] rnd_word(input int eref);
    int e;
    logic [24:0] m;
    case ($urandom_range(0, 9))
      0:          e = 0;
      1, 2, 3, 4: e = eref + int'($urandom_range(0, 8)) - 4;
      default:    e = int'($urandom_range(1, 63));
    endcase
    if (e < 0) e = 0;
    if (e > 63) e = 63;
    m = 25'($urandom);
    if ($urandom_range(0, 3) == 0) m = m & 25'h1ff0000;
    return {1'($urandom), 6'(e), m};
  endfunction

  initial begin
    logic [31:0] ra, rb;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(data_out), 64'(0));
    chk("rst_status", 64'(status_out), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h40000000, 32'h40000000, 1'b0, 0);
    run_op(32'h40000000, 32'h40000000, 1'b1, 0);
    run_op(32'h40000000, 32'h0C000000, 1'b0, 0);
    run_op(32'h7C000000, 32'h7C000000, 1'b0, 0);
    run_op(32'h02000001, 32'h82000000, 1'b0, 0);
    run_op(32'h40000000, 32'h00000000, 1'b0, 0);
    run_op(32'h80000000, 32'h00000000, 1'b1, 0);
    run_op(32'h40000001, 32'h40000000, 1'b0, 10);

    // abort mid-operation while a nonzero result is still on data_out
    @(negedge clk);
    a = 32'h41234567;
    b = 32'h3f000001;
    op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_data", 64'(data_out), 64'(0));
    chk("abort_status", 64'(status_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid), 64'(0));
    end
    run_op(32'h40000000, 32'h40000000, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      ra = rnd_word(int'($urandom_range(1, 63)));
      rb = ($urandom_range(0, 9) == 0) ? ra : rnd_word(int'(ra[30:25]));
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
